// File: rtl/psram_bus_arbiter_pkg.sv
// Shared constants for the PRG/CHR PSRAM arbiter: FSM encoding, port ids,
// default timing and PSRAM base addresses.
package psram_bus_arbiter_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_HOLD   = 2'd3;

   localparam logic PORT_PRG = 1'b0;
   localparam logic PORT_CHR = 1'b1;

   localparam int          DEFAULT_WAIT_CYCLES = 3;
   localparam logic [22:0] DEFAULT_PRG_BASE    = 23'h000000;
   localparam logic [22:0] DEFAULT_CHR_BASE    = 23'h004000;

   typedef struct packed {
      logic [22:0] addr;
      logic        lane;
      logic        r_nw;
      logic [7:0]  data;
   } req_t;

   // Byte address bit 0 is the lane select, so only the upper bits form the word offset.
   function automatic logic [22:0] map_word(input logic [22:0] base, input logic [13:0] word);
      return base + {9'd0, word};
   endfunction

endpackage

// File: rtl/psram_bus_arbiter.sv
// Round-robin arbiter sharing one asynchronous PSRAM between the PRG and CHR
// ports; sequences SETUP/ACCESS/HOLD strobes and returns a byte with a one-cycle ack.
module psram_bus_arbiter
   import psram_bus_arbiter_pkg::*;
#(
   parameter int          WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
   parameter logic [22:0] PRG_BASE    = DEFAULT_PRG_BASE,
   parameter logic [22:0] CHR_BASE    = DEFAULT_CHR_BASE
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        prg_req_in,
   input  logic [14:0] prg_a_in,
   input  logic        prg_r_nw_in,
   input  logic [7:0]  prg_d_in,
   output logic [7:0]  prg_d_out,
   output logic        prg_ack_out,
   input  logic        chr_req_in,
   input  logic [12:0] chr_a_in,
   input  logic        chr_r_nw_in,
   input  logic [7:0]  chr_d_in,
   output logic [7:0]  chr_d_out,
   output logic        chr_ack_out,
   output logic [22:0] mem_a_out,
   input  logic [15:0] mem_d_in,
   output logic [15:0] mem_d_out,
   output logic        mem_d_oe_out,
   output logic        mem_oe_n_out,
   output logic        mem_we_n_out,
   output logic        psram_ce_n_out,
   output logic        psram_lb_n_out,
   output logic        psram_ub_n_out,
   output logic        busy_out
);

   localparam int               CNT_W    = $clog2(WAIT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] wait_cnt;
   logic             last_grant;
   logic             cur_port;
   logic             cur_r_nw;
   logic             cur_lane;
   logic             grant_port;
   req_t             grant_req;
   logic [7:0]       rd_byte;

   // When both ports ask, the one that did not win last time goes first.
   always_comb begin
      grant_port = PORT_PRG;
      if (prg_req_in && chr_req_in) begin
         grant_port = (last_grant == PORT_PRG) ? PORT_CHR : PORT_PRG;
      end else if (chr_req_in) begin
         grant_port = PORT_CHR;
      end
   end

   always_comb begin
      if (grant_port == PORT_CHR) begin
         grant_req.addr = map_word(CHR_BASE, {1'b0, chr_a_in[12:1]});
         grant_req.lane = chr_a_in[0];
         grant_req.r_nw = chr_r_nw_in;
         grant_req.data = chr_d_in;
      end else begin
         grant_req.addr = map_word(PRG_BASE, prg_a_in[14:1]);
         grant_req.lane = prg_a_in[0];
         grant_req.r_nw = prg_r_nw_in;
         grant_req.data = prg_d_in;
      end
   end

   assign rd_byte = cur_lane ? mem_d_in[15:8] : mem_d_in[7:0];

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state          <= ST_IDLE;
         wait_cnt       <= '0;
         last_grant     <= PORT_CHR;
         cur_port       <= PORT_PRG;
         cur_r_nw       <= 1'b1;
         cur_lane       <= 1'b0;
         psram_ce_n_out <= 1'b1;
         mem_oe_n_out   <= 1'b1;
         mem_we_n_out   <= 1'b1;
         psram_lb_n_out <= 1'b1;
         psram_ub_n_out <= 1'b1;
         mem_d_oe_out   <= 1'b0;
         mem_a_out      <= '0;
         mem_d_out      <= '0;
         prg_ack_out    <= 1'b0;
         chr_ack_out    <= 1'b0;
         prg_d_out      <= '0;
         chr_d_out      <= '0;
         busy_out       <= 1'b0;
      end else begin
         prg_ack_out <= 1'b0;
         chr_ack_out <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (prg_req_in || chr_req_in) begin
                  state          <= ST_SETUP;
                  busy_out       <= 1'b1;
                  last_grant     <= grant_port;
                  cur_port       <= grant_port;
                  cur_r_nw       <= grant_req.r_nw;
                  cur_lane       <= grant_req.lane;
                  mem_a_out      <= grant_req.addr;
                  mem_d_out      <= {grant_req.data, grant_req.data};
                  psram_ce_n_out <= 1'b0;
                  psram_lb_n_out <= grant_req.lane;
                  psram_ub_n_out <= ~grant_req.lane;
                  mem_oe_n_out   <= ~grant_req.r_nw;
                  mem_d_oe_out   <= ~grant_req.r_nw;
               end
            end
            ST_SETUP: begin
               state    <= ST_ACCESS;
               wait_cnt <= CNT_LOAD;
               if (!cur_r_nw) begin
                  mem_we_n_out <= 1'b0;
               end
            end
            ST_ACCESS: begin
               if (wait_cnt == '0) begin
                  state          <= ST_HOLD;
                  psram_ce_n_out <= 1'b1;
                  mem_oe_n_out   <= 1'b1;
                  mem_we_n_out   <= 1'b1;
                  psram_lb_n_out <= 1'b1;
                  psram_ub_n_out <= 1'b1;
                  if (cur_port == PORT_PRG) begin
                     prg_ack_out <= 1'b1;
                     if (cur_r_nw) begin
                        prg_d_out <= rd_byte;
                     end
                  end else begin
                     chr_ack_out <= 1'b1;
                     if (cur_r_nw) begin
                        chr_d_out <= rd_byte;
                     end
                  end
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            // Write data stays driven through HOLD for data hold time.
            ST_HOLD: begin
               state        <= ST_IDLE;
               mem_d_oe_out <= 1'b0;
               busy_out     <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_psram_bus_arbiter.sv
// Randomized bench for psram_bus_arbiter: a transaction-level model predicts
// grants, strobe windows and returned bytes from the offset since each grant.
module tb_psram_bus_arbiter;
   import psram_bus_arbiter_pkg::*;

   localparam int          W             = 3;
   localparam int          HOLD_PH       = W + 2;
   localparam logic [22:0] PRG_BASE      = 23'h000000;
   localparam logic [22:0] CHR_BASE      = 23'h004000;
   localparam logic [22:0] WRAP_CHR_BASE = 23'h7FFFFF;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        prg_req_in, prg_r_nw_in, chr_req_in, chr_r_nw_in;
   logic [14:0] prg_a_in;
   logic [12:0] chr_a_in;
   logic [7:0]  prg_d_in, chr_d_in, prg_d_out, chr_d_out;
   logic        prg_ack_out, chr_ack_out;
   logic [22:0] mem_a_out;
   logic [15:0] mem_d_in, mem_d_out;
   logic        mem_d_oe_out, mem_oe_n_out, mem_we_n_out;
   logic        psram_ce_n_out, psram_lb_n_out, psram_ub_n_out, busy_out;

   logic [7:0]  w_prg_d, w_chr_d;
   logic        w_prg_ack, w_chr_ack, w_d_oe, w_oe_n, w_we_n, w_ce_n, w_lb_n, w_ub_n, w_busy;
   logic [22:0] w_mem_a;
   logic [15:0] w_mem_d;

   always #10 clk_in = ~clk_in;

   psram_bus_arbiter #(.WAIT_CYCLES(W), .PRG_BASE(PRG_BASE), .CHR_BASE(CHR_BASE)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .prg_req_in(prg_req_in), .prg_a_in(prg_a_in), .prg_r_nw_in(prg_r_nw_in), .prg_d_in(prg_d_in),
      .prg_d_out(prg_d_out), .prg_ack_out(prg_ack_out),
      .chr_req_in(chr_req_in), .chr_a_in(chr_a_in), .chr_r_nw_in(chr_r_nw_in), .chr_d_in(chr_d_in),
      .chr_d_out(chr_d_out), .chr_ack_out(chr_ack_out),
      .mem_a_out(mem_a_out), .mem_d_in(mem_d_in), .mem_d_out(mem_d_out), .mem_d_oe_out(mem_d_oe_out),
      .mem_oe_n_out(mem_oe_n_out), .mem_we_n_out(mem_we_n_out), .psram_ce_n_out(psram_ce_n_out),
      .psram_lb_n_out(psram_lb_n_out), .psram_ub_n_out(psram_ub_n_out), .busy_out(busy_out)
   );

   // Second instance only exercises 23-bit address wrap of the CHR base.
   psram_bus_arbiter #(.WAIT_CYCLES(W), .PRG_BASE(PRG_BASE), .CHR_BASE(WRAP_CHR_BASE)) dut_wrap (
      .clk_in(clk_in), .rst_in(rst_in),
      .prg_req_in(prg_req_in), .prg_a_in(prg_a_in), .prg_r_nw_in(prg_r_nw_in), .prg_d_in(prg_d_in),
      .prg_d_out(w_prg_d), .prg_ack_out(w_prg_ack),
      .chr_req_in(chr_req_in), .chr_a_in(chr_a_in), .chr_r_nw_in(chr_r_nw_in), .chr_d_in(chr_d_in),
      .chr_d_out(w_chr_d), .chr_ack_out(w_chr_ack),
      .mem_a_out(w_mem_a), .mem_d_in(mem_d_in), .mem_d_out(w_mem_d), .mem_d_oe_out(w_d_oe),
      .mem_oe_n_out(w_oe_n), .mem_we_n_out(w_we_n), .psram_ce_n_out(w_ce_n),
      .psram_lb_n_out(w_lb_n), .psram_ub_n_out(w_ub_n), .busy_out(w_busy)
   );

   function automatic logic [15:0] pat(input int i);
      return 16'(i * 40503 + 12345);
   endfunction

   // Pin-level PSRAM: bulk pattern load, single-word preset, byte-lane writes.
   logic [15:0] psram [0:32767];
   logic        mem_load, preset_en;
   logic [14:0] preset_addr;
   logic [15:0] preset_data;

   assign mem_d_in = (!psram_ce_n_out && !mem_oe_n_out) ? psram[mem_a_out[14:0]] : 16'h0000;

   always @(posedge clk_in) begin
      if (mem_load) begin
         for (int i = 0; i < 32768; i++) psram[i] <= pat(i);
      end else if (preset_en) begin
         psram[preset_addr] <= preset_data;
      end else if (!psram_ce_n_out && !mem_we_n_out) begin
         if (!psram_lb_n_out) psram[mem_a_out[14:0]][7:0] <= mem_d_out[7:0];
         if (!psram_ub_n_out) psram[mem_a_out[14:0]][15:8] <= mem_d_out[15:8];
      end
   end

   int         n_tests = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         ph = 0;
   logic       m_port = PORT_PRG, m_rnw = 1'b1, m_lane = 1'b0, m_last = PORT_CHR;
   logic [7:0] m_data = 8'h00;
   int         m_word = 0, m_word_w = 0;
   logic [7:0] exp_prg_d = 8'h00, exp_chr_d = 8'h00;
   logic [7:0] shadow [0:65535];
   bit         prg_keep = 0, chr_keep = 0;
   int         we_low_cnt = 0, oe_low_cnt = 0;
   int         ack_q[$];
   int         ack_cyc_q[$];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: an access granted at an idle edge occupies the next W+2 cycles;
   // ph is the cycle offset since that grant (0 = arbiter free).
   task automatic modelEdge();
      int idx;
      if (rst_in) begin
         ph = 0;
         m_last = PORT_CHR;
         exp_prg_d = 8'h00;
         exp_chr_d = 8'h00;
      end else if (ph == 0) begin
         if (prg_req_in || chr_req_in) begin
            if (prg_req_in && chr_req_in) m_port = (m_last == PORT_PRG) ? PORT_CHR : PORT_PRG;
            else m_port = prg_req_in ? PORT_PRG : PORT_CHR;
            m_last = m_port;
            if (m_port == PORT_PRG) begin
               m_rnw = prg_r_nw_in; m_lane = prg_a_in[0]; m_data = prg_d_in;
               m_word = (int'(PRG_BASE) + (int'(prg_a_in) >> 1)) & 32'h7FFFFF;
               m_word_w = m_word;
            end else begin
               m_rnw = chr_r_nw_in; m_lane = chr_a_in[0]; m_data = chr_d_in;
               m_word = (int'(CHR_BASE) + (int'(chr_a_in) >> 1)) & 32'h7FFFFF;
               m_word_w = (int'(WRAP_CHR_BASE) + (int'(chr_a_in) >> 1)) & 32'h7FFFFF;
            end
            if (!m_rnw) shadow[(m_word & 32'h7FFF) * 2 + int'(m_lane)] = m_data;
            ph = 1;
         end
      end else if (ph == HOLD_PH) begin
         ph = 0;
      end else begin
         ph++;
         if (ph == HOLD_PH && m_rnw) begin
            idx = (m_word & 32'h7FFF) * 2 + int'(m_lane);
            if (m_port == PORT_PRG) exp_prg_d = shadow[idx];
            else exp_chr_d = shadow[idx];
         end
      end
   endtask

   task automatic applyStimulus();
      logic [8:0] exp_vec, obs_vec;
      logic act;
      modelEdge();
      @(posedge clk_in);
      #1;
      cyc++;
      act = (ph >= 1) && (ph <= W + 1);
      exp_vec = {~act, ~(act && m_rnw), ~((ph >= 2) && (ph <= W + 1) && !m_rnw),
                 ~(act && !m_lane), ~(act && m_lane), (ph != 0) && !m_rnw, ph != 0,
                 (ph == HOLD_PH) && (m_port == PORT_PRG), (ph == HOLD_PH) && (m_port == PORT_CHR)};
      obs_vec = {psram_ce_n_out, mem_oe_n_out, mem_we_n_out, psram_lb_n_out, psram_ub_n_out,
                 mem_d_oe_out, busy_out, prg_ack_out, chr_ack_out};
      checkOutput("strobes", 32'(obs_vec), 32'(exp_vec));
      if (ph != 0) begin
         checkOutput("mem_a", 32'(mem_a_out), m_word);
         checkOutput("wrap_mem_a", 32'(w_mem_a), m_word_w);
         if (!m_rnw) checkOutput("mem_d_out", 32'(mem_d_out), 32'({m_data, m_data}));
      end
      checkOutput("prg_d_out", 32'(prg_d_out), 32'(exp_prg_d));
      checkOutput("chr_d_out", 32'(chr_d_out), 32'(exp_chr_d));
      if (!mem_we_n_out) we_low_cnt++;
      if (!mem_oe_n_out) oe_low_cnt++;
      if (prg_ack_out) begin ack_q.push_back(0); ack_cyc_q.push_back(cyc); end
      if (chr_ack_out) begin ack_q.push_back(1); ack_cyc_q.push_back(cyc); end
      if (ph == HOLD_PH) begin
         if (m_port == PORT_PRG && !prg_keep) prg_req_in = 1'b0;
         if (m_port == PORT_CHR && !chr_keep) chr_req_in = 1'b0;
      end
   endtask

   task automatic waitIdle();
      int k = 0;
      while ((ph != 0 || prg_req_in || chr_req_in) && k < 60) begin
         applyStimulus();
         k++;
      end
      checkOutput("drain_timeout", 32'(k < 60), 32'd1);
   endtask

   initial begin
      int k;
      logic [7:0] saved_chr;
      for (int i = 0; i < 32768; i++) begin
         shadow[2 * i] = pat(i) >> 0;
         shadow[2 * i + 1] = 8'(pat(i) >> 8);
      end
      rst_in = 1'b1; mem_load = 1'b1; preset_en = 1'b0; preset_addr = '0; preset_data = '0;
      prg_a_in = 15'h0123; prg_r_nw_in = 1'b1; prg_d_in = 8'h00;
      chr_a_in = 13'h0456; chr_r_nw_in = 1'b1; chr_d_in = 8'h00;
      // Both ports request continuously from reset.
      prg_req_in = 1'b1; chr_req_in = 1'b1; prg_keep = 1; chr_keep = 1;
      applyStimulus();
      mem_load = 1'b0;
      applyStimulus();
      checkOutput("rst_mem_a", 32'(mem_a_out), 32'd0);
      checkOutput("rst_mem_d_out", 32'(mem_d_out), 32'd0);
      rst_in = 1'b0;
      ack_q.delete();
      k = 0;
      while (ack_q.size() < 4 && k < 60) begin applyStimulus(); k++; end
      checkOutput("rr_timeout", 32'(k < 60), 32'd1);
      checkOutput("rr_grant0", 32'(ack_q[0]), 32'd0);
      checkOutput("rr_grant1", 32'(ack_q[1]), 32'd1);
      checkOutput("rr_grant2", 32'(ack_q[2]), 32'd0);
      checkOutput("rr_grant3", 32'(ack_q[3]), 32'd1);
      prg_keep = 0; chr_keep = 0; chr_req_in = 1'b0;
      waitIdle();

      // PRG read of the high byte of word 1.
      preset_en = 1'b1; preset_addr = 15'h0001; preset_data = 16'hA55A;
      shadow[2] = 8'h5A; shadow[3] = 8'hA5;
      applyStimulus();
      preset_en = 1'b0;
      prg_req_in = 1'b1; prg_a_in = 15'h0003; prg_r_nw_in = 1'b1;
      oe_low_cnt = 0; k = 0;
      while (!prg_ack_out && k < 20) begin applyStimulus(); k++; end
      checkOutput("prg_latency", 32'(k), 32'(W + 2));
      checkOutput("prg_oe_len", 32'(oe_low_cnt), 32'(W + 1));
      checkOutput("prg_rd_byte", 32'(prg_d_out), 32'hA5);
      waitIdle();

      // CHR write of byte 0.
      chr_req_in = 1'b1; chr_a_in = 13'h0000; chr_r_nw_in = 1'b0; chr_d_in = 8'h3C;
      we_low_cnt = 0; k = 0;
      while (!chr_ack_out && k < 20) begin applyStimulus(); k++; end
      checkOutput("chr_wr_latency", 32'(k), 32'(W + 2));
      checkOutput("chr_we_len", 32'(we_low_cnt), 32'(W));
      waitIdle();
      checkOutput("chr_wr_mem", 32'(psram[16'h4000] & 16'h00FF), 32'h3C);

      // Back-to-back PRG reads with request held.
      saved_chr = exp_chr_d;
      prg_req_in = 1'b1; prg_a_in = 15'h0040; prg_r_nw_in = 1'b1; prg_keep = 1;
      ack_cyc_q.delete(); k = 0;
      while (ack_cyc_q.size() < 3 && k < 40) begin applyStimulus(); k++; end
      checkOutput("b2b_timeout", 32'(k < 40), 32'd1);
      checkOutput("b2b_period0", 32'(ack_cyc_q[1] - ack_cyc_q[0]), 32'(W + 3));
      checkOutput("b2b_period1", 32'(ack_cyc_q[2] - ack_cyc_q[1]), 32'(W + 3));
      checkOutput("b2b_chr_hold", 32'(chr_d_out), 32'(saved_chr));
      prg_keep = 0; prg_req_in = 1'b0;
      waitIdle();

      // CHR read at byte 2 on the wrapping instance lands on word 0.
      chr_req_in = 1'b1; chr_a_in = 13'h0002; chr_r_nw_in = 1'b1;
      applyStimulus();
      checkOutput("wrap_zero", 32'(w_mem_a), 32'd0);
      waitIdle();

      // Reset in the middle of ACCESS aborts without ack.
      prg_req_in = 1'b1; prg_a_in = 15'h0010; prg_r_nw_in = 1'b1;
      k = 0;
      while (ph != 3 && k < 20) begin applyStimulus(); k++; end
      rst_in = 1'b1; prg_req_in = 1'b0;
      applyStimulus();
      checkOutput("rst_abort_strobes",
                  32'({psram_ce_n_out, mem_oe_n_out, mem_we_n_out, psram_lb_n_out, psram_ub_n_out}), 32'h1F);
      checkOutput("rst_abort_doe_busy", 32'({mem_d_oe_out, busy_out}), 32'd0);
      checkOutput("rst_abort_mem_a", 32'(mem_a_out), 32'd0);
      rst_in = 1'b0;
      ack_q.delete();
      repeat (8) applyStimulus();
      checkOutput("rst_no_ack", 32'(ack_q.size()), 32'd0);

      // Random traffic from both ports, inputs scrambled after grant.
      for (int i = 0; i < 400; i++) begin
         if (!prg_req_in && $urandom_range(0, 2) == 0) begin
            prg_req_in = 1'b1;
            prg_r_nw_in = 1'($urandom_range(0, 1));
            prg_a_in = ($urandom_range(0, 1) == 1) ? 15'($urandom) : 15'($urandom_range(0, 15));
            prg_d_in = 8'($urandom);
         end else if (prg_req_in && ph >= 1 && m_port == PORT_PRG) begin
            prg_a_in = 15'($urandom); prg_d_in = 8'($urandom); prg_r_nw_in = 1'($urandom);
         end
         if (!chr_req_in && $urandom_range(0, 2) == 0) begin
            chr_req_in = 1'b1;
            chr_r_nw_in = 1'($urandom_range(0, 1));
            chr_a_in = ($urandom_range(0, 1) == 1) ? 13'($urandom) : 13'($urandom_range(0, 15));
            chr_d_in = 8'($urandom);
         end else if (chr_req_in && ph >= 1 && m_port == PORT_CHR) begin
            chr_a_in = 13'($urandom); chr_d_in = 8'($urandom); chr_r_nw_in = 1'($urandom);
         end
         applyStimulus();
      end
      waitIdle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
